// File: rtl/cia_pkg.sv
// Shared definitions for the CIA-style timer responder: register offsets, CR/ICR bit positions.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package cia_pkg;

    // Register offsets within the 16-byte window (ab[3:0]).
    localparam logic [3:0] OFF_TA_LO = 4'h0;
    localparam logic [3:0] OFF_TA_HI = 4'h1;
    localparam logic [3:0] OFF_TB_LO = 4'h2;
    localparam logic [3:0] OFF_TB_HI = 4'h3;
    localparam logic [3:0] OFF_ICR   = 4'h4;
    localparam logic [3:0] OFF_CRA   = 4'h5;
    localparam logic [3:0] OFF_CRB   = 4'h6;

    // Control register bit positions.
    localparam int CR_START      = 0;
    localparam int CR_ONESHOT    = 3;
    localparam int CR_FORCE_LOAD = 4;
    localparam int CR_CHAIN      = 6;

    // Interrupt control register layout.
    localparam int ICR_TA     = 0;
    localparam int ICR_TB     = 1;
    localparam int ICR_IRQ    = 7;
    localparam int ICR_FLAG_W = 5;

    // Byte returned by an ICR read: {irq, 2'b0, flags}.
    function automatic logic [7:0] icr_read_byte(input logic irq, input logic [ICR_FLAG_W-1:0] flags);
        logic [7:0] b;
        b = 8'h00;
        b[ICR_FLAG_W-1:0] = flags;
        b[ICR_IRQ] = irq;
        return b;
    endfunction

endpackage

// File: rtl/cia_timer_unit.sv
// One 16-bit interval timer: latch, down-counter, control register, underflow pulse.
// Latency: counter/cr update on the clock after the write or count event; underflow is combinational.
// Backpressure: none; every write and count event is accepted in its cycle.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   count_en         one-cycle count event (tick or chained underflow)
//   wr_lo, wr_hi     latch byte write strobes, data on wd
//   cr_wr, cr_wd     control register write strobe and data
//   counter, cr      live counter and stored control register (FORCE_LOAD always 0)
//   underflow        high in the cycle the counter wraps from 0 to the latch
module cia_timer_unit
    import cia_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        count_en,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [7:0]  wd,
    input  logic        cr_wr,
    input  logic [7:0]  cr_wd,
    output logic [15:0] counter,
    output logic [7:0]  cr,
    output logic        underflow
);

    logic [15:0] latch;
    logic [7:0]  cr_next;
    logic        force_load;
    logic        running;

    assign force_load = cr_wr && cr_wd[CR_FORCE_LOAD];
    assign running    = cr[CR_START];

    // A force load in the same cycle suppresses the underflow entirely.
    assign underflow = running && count_en && (counter == 16'h0000) && !force_load;

    always_comb begin
        cr_next = cr;
        if (cr_wr) begin
            cr_next = cr_wd;
            cr_next[CR_FORCE_LOAD] = 1'b0;   // strobe, never stored
        end
        // One-shot stop is applied after any CPU write so it always wins.
        if (underflow && cr[CR_ONESHOT]) begin
            cr_next[CR_START] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            latch   <= 16'hFFFF;
            counter <= 16'hFFFF;
            cr      <= 8'h00;
        end else begin
            cr <= cr_next;

            if (wr_lo) latch[7:0]  <= wd;
            if (wr_hi) latch[15:8] <= wd;

            // Reloads read the pre-edge latch, so a same-cycle latch write
            // only takes effect on the following reload.
            if (force_load) begin
                counter <= latch;
            end else if (running && count_en) begin
                counter <= (counter == 16'h0000) ? latch : counter - 16'd1;
            end else if (wr_hi && !running) begin
                counter <= {wd, latch[7:0]};
            end
        end
    end

endmodule

// File: rtl/cia_timer_responder.sv
// CIA-style bus responder: two interval timers, ICR flag/mask, irq, 16-byte register window.
// Latency: read data and rd_hit one clock after the address; irq registered one clock after the event.
// Backpressure: none; the CPU bus is always accepted, unselected cycles return rd_data = 0.
//
// Ports:
//   clk, reset   clock, synchronous active-high reset
//   ab, we       CPU address bus and write enable
//   cpu_do       CPU write data
//   tick         phi2 count enable for the timers
//   rd_data      registered read data, zero when not selected (OR-able into the data mux)
//   rd_hit       registered select for rd_data
//   irq          registered active-high interrupt request
module cia_timer_responder
    import cia_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR = 16'hDC00
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] ab,
    input  logic        we,
    input  logic [7:0]  cpu_do,
    input  logic        tick,
    output logic [7:0]  rd_data,
    output logic        rd_hit,
    output logic        irq
);

    logic                  hit;
    logic [3:0]            off;
    logic                  wr_en;
    logic                  rd_en;
    logic                  icr_rd;
    logic                  icr_wr;

    logic [15:0]           cnt_a;
    logic [15:0]           cnt_b;
    logic [7:0]            cr_a;
    logic [7:0]            cr_b;
    logic                  uf_a;
    logic                  uf_b;
    logic                  cnt_en_b;

    logic [ICR_FLAG_W-1:0] flags;
    logic [ICR_FLAG_W-1:0] flags_next;
    logic [ICR_FLAG_W-1:0] mask;
    logic [ICR_FLAG_W-1:0] mask_next;
    logic [7:0]            rd_mux;

    assign hit    = (ab[15:4] == BASE_ADDR[15:4]);
    assign off    = ab[3:0];
    assign wr_en  = hit && we;
    assign rd_en  = hit && !we;    // dummy CPU reads count as reads too
    assign icr_rd = rd_en && (off == OFF_ICR);
    assign icr_wr = wr_en && (off == OFF_ICR);

    // Chained mode counts timer A underflow pulses instead of phi2 ticks.
    assign cnt_en_b = cr_b[CR_CHAIN] ? uf_a : tick;

    cia_timer_unit u_timer_a (
        .clk       (clk),
        .reset     (reset),
        .count_en  (tick),
        .wr_lo     (wr_en && (off == OFF_TA_LO)),
        .wr_hi     (wr_en && (off == OFF_TA_HI)),
        .wd        (cpu_do),
        .cr_wr     (wr_en && (off == OFF_CRA)),
        .cr_wd     (cpu_do),
        .counter   (cnt_a),
        .cr        (cr_a),
        .underflow (uf_a)
    );

    cia_timer_unit u_timer_b (
        .clk       (clk),
        .reset     (reset),
        .count_en  (cnt_en_b),
        .wr_lo     (wr_en && (off == OFF_TB_LO)),
        .wr_hi     (wr_en && (off == OFF_TB_HI)),
        .wd        (cpu_do),
        .cr_wr     (wr_en && (off == OFF_CRB)),
        .cr_wd     (cpu_do),
        .counter   (cnt_b),
        .cr        (cr_b),
        .underflow (uf_b)
    );

    // Read-clear happens first and underflows are OR-ed in afterwards, so an
    // underflow coinciding with an ICR read keeps its flag.
    always_comb begin
        flags_next = icr_rd ? '0 : flags;
        flags_next[ICR_TA] = flags_next[ICR_TA] | uf_a;
        flags_next[ICR_TB] = flags_next[ICR_TB] | uf_b;
    end

    always_comb begin
        mask_next = mask;
        if (icr_wr) begin
            if (cpu_do[ICR_IRQ]) mask_next = mask | cpu_do[ICR_FLAG_W-1:0];
            else                 mask_next = mask & ~cpu_do[ICR_FLAG_W-1:0];
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        case (off)
            OFF_TA_LO: rd_mux = cnt_a[7:0];
            OFF_TA_HI: rd_mux = cnt_a[15:8];
            OFF_TB_LO: rd_mux = cnt_b[7:0];
            OFF_TB_HI: rd_mux = cnt_b[15:8];
            OFF_ICR:   rd_mux = icr_read_byte(irq, flags);
            OFF_CRA:   rd_mux = cr_a;
            OFF_CRB:   rd_mux = cr_b;
            default:   rd_mux = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data <= 8'h00;
            rd_hit  <= 1'b0;
            irq     <= 1'b0;
            flags   <= '0;
            mask    <= '0;
        end else begin
            rd_data <= rd_en ? rd_mux : 8'h00;
            rd_hit  <= rd_en;
            flags   <= flags_next;
            mask    <= mask_next;
            irq     <= |(flags_next & mask_next);
        end
    end

endmodule

// File: tb/tb_cia_timer_responder.sv
module tb_cia_timer_responder;

    localparam logic [15:0] BASE = 16'hDC00;
    localparam logic [15:0] IDLE = 16'h0000;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] ab;
    logic        we;
    logic [7:0]  cpu_do;
    logic        tick;
    logic [7:0]  rd_data;
    logic        rd_hit;
    logic        irq;

    int tests = 0;
    int fails = 0;

    cia_timer_responder #(.BASE_ADDR(BASE)) dut (
        .clk     (clk),
        .reset   (reset),
        .ab      (ab),
        .we      (we),
        .cpu_do  (cpu_do),
        .tick    (tick),
        .rd_data (rd_data),
        .rd_hit  (rd_hit),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [3:0] off, input logic [7:0] d);
        ab = BASE | {12'h000, off};
        we = 1'b1;
        cpu_do = d;
        step();
        ab = IDLE;
        we = 1'b0;
        cpu_do = 8'h00;
    endtask

    task automatic rd(input logic [3:0] off, input logic [7:0] exp, input string tag);
        ab = BASE | {12'h000, off};
        we = 1'b0;
        step();
        chk(tag, rd_data, exp);
        ab = IDLE;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    initial begin
        reset = 1'b1; ab = IDLE; we = 1'b0; cpu_do = 8'h00; tick = 1'b0;
        step(); step();
        chk("reset_rd_data", rd_data, 8'h00);
        chk("reset_rd_hit", {7'b0, rd_hit}, 8'h00);
        chk("reset_irq", {7'b0, irq}, 8'h00);
        reset = 1'b0;

        // 1. reset values through the bus
        rd(4'h0, 8'hFF, "rst_ta_lo");
        chk("rd_hit_on_read", {7'b0, rd_hit}, 8'h01);
        rd(4'h1, 8'hFF, "rst_ta_hi");
        rd(4'h4, 8'h00, "rst_icr");
        rd(4'h5, 8'h00, "rst_cra");
        wr(4'h7, 8'h5A);
        rd(4'h7, 8'h00, "unused_off7");
        ab = 16'hD000; we = 1'b0; step();
        chk("d000_rd_hit", {7'b0, rd_hit}, 8'h00);
        chk("d000_rd_data", rd_data, 8'h00);
        ab = IDLE;

        // 2. continuous timer A, latch 3
        wr(4'h0, 8'h03);
        wr(4'h1, 8'h00);
        rd(4'h0, 8'h03, "ta_stopped_hi_load");
        wr(4'h5, 8'h11);
        rd(4'h5, 8'h01, "cra_force_load_reads0");
        tick = 1'b1;
        rd(4'h0, 8'h03, "cnt_t1");
        rd(4'h0, 8'h02, "cnt_t2");
        rd(4'h0, 8'h01, "cnt_t3");
        rd(4'h0, 8'h00, "cnt_t4");
        rd(4'h0, 8'h03, "cnt_t5_reloaded");
        tick = 1'b0;
        rd(4'h4, 8'h01, "icr_uf_tick4");
        ticks(2);
        rd(4'h4, 8'h00, "icr_no_uf_tick7");
        ticks(1);
        rd(4'h4, 8'h01, "icr_uf_tick8");
        wr(4'h5, 8'h00);

        // 3. one-shot, latch 2
        wr(4'h0, 8'h02);
        wr(4'h1, 8'h00);
        wr(4'h5, 8'h19);
        tick = 1'b1;
        rd(4'h0, 8'h02, "os_t1");
        rd(4'h0, 8'h01, "os_t2");
        rd(4'h0, 8'h00, "os_t3");
        tick = 1'b0;
        rd(4'h5, 8'h08, "os_cra_stopped");
        tick = 1'b1;
        rd(4'h0, 8'h02, "os_hold1");
        rd(4'h0, 8'h02, "os_hold2");
        tick = 1'b0;
        rd(4'h4, 8'h01, "os_icr");

        // 4. masked interrupt
        wr(4'h4, 8'h81);
        wr(4'h5, 8'h19);
        ticks(2);
        chk("irq_before_uf", {7'b0, irq}, 8'h00);
        ticks(1);
        chk("irq_after_uf", {7'b0, irq}, 8'h01);
        rd(4'h4, 8'h81, "icr_with_irq");
        chk("irq_cleared_by_read", {7'b0, irq}, 8'h00);
        wr(4'h4, 8'h01);
        wr(4'h5, 8'h19);
        ticks(3);
        chk("irq_masked_off", {7'b0, irq}, 8'h00);
        rd(4'h4, 8'h01, "icr_masked_flag");

        // 5. chained timer B
        wr(4'h0, 8'h01);
        wr(4'h1, 8'h00);
        wr(4'h2, 8'h02);
        wr(4'h3, 8'h00);
        wr(4'h6, 8'h41);
        rd(4'h6, 8'h41, "crb_readback");
        wr(4'h5, 8'h11);
        ticks(5);
        rd(4'h2, 8'h00, "tb_after5");
        rd(4'h4, 8'h01, "icr_after5");
        ticks(1);
        rd(4'h4, 8'h03, "icr_tb_uf_tick6");
        rd(4'h2, 8'h02, "tb_reloaded");

        // 6. read-clear racing an underflow, force load beating an underflow, reset
        wr(4'h6, 8'h00);
        ticks(1);
        tick = 1'b1;
        rd(4'h4, 8'h00, "icr_read_at_uf");
        tick = 1'b0;
        rd(4'h4, 8'h01, "flag_survives_read");
        ticks(1);
        tick = 1'b1;
        wr(4'h5, 8'h11);
        tick = 1'b0;
        rd(4'h4, 8'h00, "force_load_no_flag");
        rd(4'h0, 8'h01, "force_load_value");
        wr(4'h4, 8'h81);
        ticks(2);
        chk("irq_before_reset", {7'b0, irq}, 8'h01);
        reset = 1'b1; tick = 1'b1;
        step();
        reset = 1'b0; tick = 1'b0;
        chk("mid_reset_irq", {7'b0, irq}, 8'h00);
        chk("mid_reset_rd_hit", {7'b0, rd_hit}, 8'h00);
        rd(4'h0, 8'hFF, "mid_reset_ta_lo");
        rd(4'h1, 8'hFF, "mid_reset_ta_hi");
        rd(4'h3, 8'hFF, "mid_reset_tb_hi");
        rd(4'h5, 8'h00, "mid_reset_cra");
        rd(4'h4, 8'h00, "mid_reset_icr");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
